// File: rtl/sal_dram_pkg.sv
// rtl/sal_dram_pkg.sv - shared DRAM command codes, refresh states and timing helper
package sal_dram_pkg;

    localparam int AP_BIT = 10;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_PREA = 3'd5,
        CMD_REF  = 3'd6
    } cmd_e;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_REF_PRE  = 2'd1,
        ST_REF_WAIT = 2'd2
    } ref_state_e;

    // A load of v leaves v-1 so the dependent command lands exactly v cycles later; v=0 acts as v=1.
    function automatic logic [31:0] tcnt_next(input logic load, input logic [31:0] v,
                                              input logic [31:0] cur);
        if (load) return (v == 32'd0) ? 32'd0 : v - 32'd1;
        return (cur == 32'd0) ? 32'd0 : cur - 32'd1;
    endfunction

endpackage

// File: rtl/sal_mbank_ctrl_if.sv
// rtl/sal_mbank_ctrl_if.sv - in-order request stream from the address decoder
interface sal_mbank_ctrl_if #(
    parameter int BA_WIDTH = 2,
    parameter int RA_WIDTH = 14,
    parameter int CA_WIDTH = 10
);

    logic                req_valid;
    logic                req_ready;
    logic                req_wr;
    logic [BA_WIDTH-1:0] req_ba;
    logic [RA_WIDTH-1:0] req_ra;
    logic [CA_WIDTH-1:0] req_ca;

    modport master (
        output req_valid,
        output req_wr,
        output req_ba,
        output req_ra,
        output req_ca,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_wr,
        input  req_ba,
        input  req_ra,
        input  req_ca,
        output req_ready
    );

endinterface

// File: rtl/sal_bank_tracker.sv
// rtl/sal_bank_tracker.sv - per-bank open/row/accessed state and bank timing counters
module sal_bank_tracker
    import sal_dram_pkg::*;
#(
    parameter int RA_WIDTH = 14,
    parameter int TW       = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                act,
    input  logic                pre,
    input  logic                rd,
    input  logic                wr,
    input  logic [RA_WIDTH-1:0] act_row,
    input  logic [TW-1:0]       t_rcd,
    input  logic [TW-1:0]       t_rp,
    input  logic [TW-1:0]       t_ras,
    input  logic [TW-1:0]       t_rtp,
    input  logic [TW-1:0]       t_wtp,
    output logic                is_open,
    output logic                is_accessed,
    output logic [RA_WIDTH-1:0] row,
    output logic                rcd_met,
    output logic                rp_met,
    output logic                ras_met,
    output logic                rtp_met,
    output logic                wtp_met
);

    logic                open_q, open_d;
    logic                accessed_q, accessed_d;
    logic [RA_WIDTH-1:0] row_q, row_d;
    logic [TW-1:0]       rcd_q, rcd_d;
    logic [TW-1:0]       rp_q, rp_d;
    logic [TW-1:0]       ras_q, ras_d;
    logic [TW-1:0]       rtp_q, rtp_d;
    logic [TW-1:0]       wtp_q, wtp_d;

    always_comb begin
        open_d = open_q;
        if (act) open_d = 1'b1;
        if (pre) open_d = 1'b0;

        row_d = act ? act_row : row_q;

        accessed_d = accessed_q;
        if (rd || wr) accessed_d = 1'b1;
        if (act)      accessed_d = 1'b0;

        rcd_d = TW'(tcnt_next(act, 32'(t_rcd), 32'(rcd_q)));
        ras_d = TW'(tcnt_next(act, 32'(t_ras), 32'(ras_q)));
        rp_d  = TW'(tcnt_next(pre, 32'(t_rp),  32'(rp_q)));
        rtp_d = TW'(tcnt_next(rd,  32'(t_rtp), 32'(rtp_q)));
        wtp_d = TW'(tcnt_next(wr,  32'(t_wtp), 32'(wtp_q)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q     <= 1'b0;
            accessed_q <= 1'b0;
            row_q      <= '0;
            rcd_q      <= '0;
            rp_q       <= '0;
            ras_q      <= '0;
            rtp_q      <= '0;
            wtp_q      <= '0;
        end else begin
            open_q     <= open_d;
            accessed_q <= accessed_d;
            row_q      <= row_d;
            rcd_q      <= rcd_d;
            rp_q       <= rp_d;
            ras_q      <= ras_d;
            rtp_q      <= rtp_d;
            wtp_q      <= wtp_d;
        end
    end

    assign is_open     = open_q;
    assign is_accessed = accessed_q;
    assign row         = row_q;
    assign rcd_met     = (rcd_q == '0);
    assign rp_met      = (rp_q == '0);
    assign ras_met     = (ras_q == '0);
    assign rtp_met     = (rtp_q == '0);
    assign wtp_met     = (wtp_q == '0);

endmodule

// File: rtl/sal_mbank_ctrl.sv
// rtl/sal_mbank_ctrl.sv - multi-bank DRAM command scheduler with all-bank refresh and page policy
module sal_mbank_ctrl
    import sal_dram_pkg::*;
#(
    parameter int  NUM_BANKS   = 4,
    parameter int  RA_WIDTH    = 14,
    parameter int  CA_WIDTH    = 10,
    parameter int  TW          = 5,
    parameter int  PAGE_POLICY = 0,
    localparam int BA_WIDTH    = $clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 rst,
    sal_mbank_ctrl_if.slave      req_if,
    input  logic                 ref_req,
    output logic                 ref_gnt,
    input  logic [TW-1:0]        t_rcd,
    input  logic [TW-1:0]        t_rp,
    input  logic [TW-1:0]        t_ras,
    input  logic [TW-1:0]        t_rtp,
    input  logic [TW-1:0]        t_wtp,
    input  logic [TW-1:0]        t_rrd,
    input  logic [TW-1:0]        t_ccd,
    input  logic [TW-1:0]        t_rfc,
    output logic [2:0]           cmd_code,
    output logic [BA_WIDTH-1:0]  cmd_ba,
    output logic [RA_WIDTH-1:0]  cmd_addr,
    output logic [NUM_BANKS-1:0] bank_open
);

    logic [NUM_BANKS-1:0] open_w, accessed_w;
    logic [NUM_BANKS-1:0] rcd_met, rp_met, ras_met, rtp_met, wtp_met, pre_ok;
    logic [RA_WIDTH-1:0]  row_w [NUM_BANKS];
    logic [NUM_BANKS-1:0] act_v, pre_v, rd_v, wr_v;

    ref_state_e           state_q, state_d;
    cmd_e                 cmd_q, cmd_d;
    logic [BA_WIDTH-1:0]  ba_q, ba_d;
    logic [RA_WIDTH-1:0]  addr_q, addr_d;
    logic [TW-1:0]        rrd_q, rrd_d, ccd_q, ccd_d, rfc_q, rfc_d;
    logic                 ready_c, gnt_c, found;
    logic [BA_WIDTH-1:0]  tgt;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        sal_bank_tracker #(
            .RA_WIDTH (RA_WIDTH),
            .TW       (TW)
        ) u_bank (
            .clk         (clk),
            .rst         (rst),
            .act         (act_v[i]),
            .pre         (pre_v[i]),
            .rd          (rd_v[i]),
            .wr          (wr_v[i]),
            .act_row     (req_if.req_ra),
            .t_rcd       (t_rcd),
            .t_rp        (t_rp),
            .t_ras       (t_ras),
            .t_rtp       (t_rtp),
            .t_wtp       (t_wtp),
            .is_open     (open_w[i]),
            .is_accessed (accessed_w[i]),
            .row         (row_w[i]),
            .rcd_met     (rcd_met[i]),
            .rp_met      (rp_met[i]),
            .ras_met     (ras_met[i]),
            .rtp_met     (rtp_met[i]),
            .wtp_met     (wtp_met[i])
        );
    end

    assign pre_ok = ras_met & rtp_met & wtp_met;
    assign tgt    = req_if.req_ba;

    always_comb begin
        state_d = state_q;
        cmd_d   = CMD_NOP;
        ba_d    = '0;
        addr_d  = '0;
        ready_c = 1'b0;
        gnt_c   = 1'b0;
        found   = 1'b0;
        act_v   = '0;
        pre_v   = '0;
        rd_v    = '0;
        wr_v    = '0;
        if (!rst) begin
            unique case (state_q)
                ST_NORMAL: begin
                    // Refresh wins over the request; the request stays pending upstream.
                    if (ref_req) begin
                        state_d = (|open_w) ? ST_REF_PRE : ST_REF_WAIT;
                    end else begin
                        if (req_if.req_valid) begin
                            if (!open_w[tgt]) begin
                                if (rp_met[tgt] && rrd_q == '0 && rfc_q == '0) begin
                                    cmd_d      = CMD_ACT;
                                    ba_d       = tgt;
                                    addr_d     = req_if.req_ra;
                                    act_v[tgt] = 1'b1;
                                end
                            end else if (row_w[tgt] == req_if.req_ra) begin
                                if (rcd_met[tgt] && ccd_q == '0) begin
                                    cmd_d   = req_if.req_wr ? CMD_WR : CMD_RD;
                                    ba_d    = tgt;
                                    addr_d  = RA_WIDTH'(req_if.req_ca);
                                    ready_c = 1'b1;
                                    if (req_if.req_wr) wr_v[tgt] = 1'b1;
                                    else               rd_v[tgt] = 1'b1;
                                end
                            end else if (pre_ok[tgt]) begin
                                cmd_d      = CMD_PRE;
                                ba_d       = tgt;
                                pre_v[tgt] = 1'b1;
                            end
                        end
                        if (PAGE_POLICY != 0 && cmd_d == CMD_NOP) begin
                            for (int i = 0; i < NUM_BANKS; i++) begin
                                if (!found && open_w[i] && accessed_w[i] && pre_ok[i] &&
                                    !(req_if.req_valid && tgt == BA_WIDTH'(i))) begin
                                    found    = 1'b1;
                                    cmd_d    = CMD_PRE;
                                    ba_d     = BA_WIDTH'(i);
                                    pre_v[i] = 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_REF_PRE: begin
                    if ((open_w & ~pre_ok) == '0) begin
                        cmd_d          = CMD_PREA;
                        addr_d[AP_BIT] = 1'b1;
                        pre_v          = '1;
                        state_d        = ST_REF_WAIT;
                    end
                end
                ST_REF_WAIT: begin
                    if ((&rp_met) && rfc_q == '0) begin
                        cmd_d   = CMD_REF;
                        gnt_c   = 1'b1;
                        state_d = ST_NORMAL;
                    end
                end
                default: state_d = ST_NORMAL;
            endcase
        end
    end

    always_comb begin
        rrd_d = TW'(tcnt_next(cmd_d == CMD_ACT, 32'(t_rrd), 32'(rrd_q)));
        ccd_d = TW'(tcnt_next(cmd_d == CMD_RD || cmd_d == CMD_WR, 32'(t_ccd), 32'(ccd_q)));
        rfc_d = TW'(tcnt_next(cmd_d == CMD_REF, 32'(t_rfc), 32'(rfc_q)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_NORMAL;
            cmd_q   <= CMD_NOP;
            ba_q    <= '0;
            addr_q  <= '0;
            rrd_q   <= '0;
            ccd_q   <= '0;
            rfc_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            rrd_q   <= rrd_d;
            ccd_q   <= ccd_d;
            rfc_q   <= rfc_d;
        end
    end

    assign req_if.req_ready = ready_c;
    assign ref_gnt          = gnt_c;
    assign cmd_code         = cmd_q;
    assign cmd_ba           = ba_q;
    assign cmd_addr         = addr_q;
    assign bank_open        = open_w;

endmodule

// File: doc/sal_mbank_ctrl.md
Name: sal_mbank_ctrl

Overview:
Parametrised multi-bank DRAM command scheduler and the successor to the single-bank controller. It tracks open/closed state and the open row for NUM_BANKS banks, and issues ACT/RD/WR/PRE for one in-order request stream. It runs an all-bank refresh sequence (PREA, then REF) and supports open-page or close-page policy. It sits between the address decoder and the DFI command encoder.

Parameters:
NUM_BANKS, 4, number of banks (power of 2, ≥2); BA_WIDTH = log2(NUM_BANKS)
RA_WIDTH, 14, row address width (must be >10)
CA_WIDTH, 10, column address width (must be ≤10)
TW, 5, width of every timing input and counter
PAGE_POLICY, 0, 0 = open-page, 1 = close-page

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request consumed this cycle (combinational)
req_wr  in  1  1 = write, 0 = read
req_ba  in  BA_WIDTH  target bank
req_ra  in  RA_WIDTH  row
req_ca  in  CA_WIDTH  column
ref_req  in  1  refresh request (level)
ref_gnt  out  1  one-cycle pulse when REF is granted
t_rcd, t_rp, t_ras, t_rtp, t_wtp, t_rrd, t_ccd, t_rfc  in  TW each  timing values in cycles; quasi-static
cmd_code  out  3  registered command: NOP=0, ACT=1, RD=2, WR=3, PRE=4, PREA=5, REF=6
cmd_ba  out  BA_WIDTH  registered bank
cmd_addr  out  RA_WIDTH  registered row, or zero-extended column
bank_open  out  NUM_BANKS  per-bank open flag (registered state)

Behaviour:
- Reset:
  - All banks closed; rows = 0; all counters = 0; FSM = NORMAL.
  - cmd_code = NOP, cmd_ba = 0, cmd_addr = 0; req_ready = 0; ref_gnt = 0; bank_open = 0.
  - Reset mid-refresh abandons the sequence with no REF issued.
- Issue rate and latency:
  - At most one command is granted per cycle.
  - cmd_* reflect the grant on the next clk edge (1-cycle latency).
  - With no grant, cmd_* = NOP / 0 / 0.
- Timing counters:
  - A grant loads max(v,1)−1, where v is the timing value; the counter decrements to a floor of 0; "met" means the counter is 0.
  - Result: a dependent command may be granted v cycles after the loading grant. v = 0 is treated as v = 1.
  - Per-bank counters: rcd (loaded by ACT), rp (PRE/PREA), ras (ACT), rtp (RD), wtp (WR).
  - Global counters: rrd (ACT), ccd (RD/WR), rfc (REF).
- NORMAL state, req_valid=1 and ref_req=0, bank b = req_ba:
  - Bank b closed: grant ACT if rp[b], rrd and rfc are met. Bank b opens with row = req_ra. req_ready = 0.
  - Bank b open, row hit: grant RD or WR per req_wr if rcd[b] and ccd are met. req_ready = 1 in the same cycle. cmd_addr = req_ca with bit 10 = 0.
  - Bank b open, row miss: grant PRE to b if ras[b], rtp[b] and wtp[b] are met. Bank b closes.
- Close-page policy (PAGE_POLICY=1):
  - Each bank has an accessed flag, set by RD/WR and cleared by ACT.
  - In a cycle where the request path grants nothing, PRE the lowest-index bank that is open, accessed, not targeted by the current valid request, and has ras/rtp/wtp met.
- Refresh FSM (NORMAL, REF_PRE, REF_WAIT):
  - NORMAL with ref_req=1: no request or close-page grants that cycle and req_ready = 0. Next state is REF_PRE if any bank is open, else REF_WAIT.
  - REF_PRE: grant PREA (cmd_addr[10] = 1, cmd_ba = 0) once every open bank meets ras/rtp/wtp. All banks close and all rp counters load. Next state REF_WAIT.
  - REF_WAIT: grant REF once all rp counters and rfc are met. ref_gnt = 1 in the grant cycle. Next state NORMAL.
  - Refresh is committed once the FSM leaves NORMAL; de-asserting ref_req afterwards does not cancel it.
  - req_valid is ignored (ready = 0) outside NORMAL.
- Simultaneous events: ref_req outranks a same-cycle ready request; that request is held, not dropped.
- Requester handshake: the requester must hold req_* stable until req_ready.

Decomposition:
- Shared package sal_dram_pkg: cmd_code enum, refresh FSM enum, AP_BIT = 10 constant.
- Sub-module sal_bank_tracker, instantiated NUM_BANKS times:
  - open flag, row register, accessed flag;
  - rcd/rp/ras/rtp/wtp counters;
  - met outputs;
  - open/close/access strobes in.
- Global counters and the FSM live in the top module.

Test Plan:
- Closed-bank read:
  - Stimulus: t_rcd=3, req(rd, ba1, ra 0x12, ca 0x8).
  - Required: ACT ba1 addr 0x12 at cycle N; RD ba1 addr 0x008 at N+3; req_ready high in the RD grant cycle only.
- Row miss:
  - Stimulus: bank 2 open at row 0x5, t_ras=6, t_rp=2; request ra 0x6 arrives 1 cycle after ACT.
  - Required: PRE ba2 at ACT+6; ACT 0x6 at PRE+2; then RD.
- Bank interleave:
  - Stimulus: t_rrd=2; back-to-back requests to ba0 and ba1, both closed.
  - Required: ACTs exactly 2 cycles apart. With t_ccd=4, consecutive RDs are ≥4 cycles apart.
- Refresh with open banks:
  - Stimulus: banks 0 and 3 open, ref_req=1, t_rp=3, t_rfc=8, plus a hit request pending.
  - Required: PREA with addr[10]=1; REF 3 cycles later; ref_gnt pulses 1 cycle; ACT is not granted before REF+8; the held request completes afterwards.
- Close-page:
  - Stimulus: PAGE_POLICY=1, single WR to ba2, t_wtp=5.
  - Required: PRE ba2 issued 5 cycles after WR; bank_open[2] returns to 0.
- Reset mid-sequence:
  - Stimulus: assert rst during REF_WAIT.
  - Required: next cycle cmd_code = NOP, bank_open = 0, ref_gnt = 0; a fresh ref_req yields REF without PREA.
